// File: rtl/uart_mmio_periph_if.sv
// ---------------------------------------------------------------------------
// uart_mmio_periph_if
// Purpose : UART slice of the memory controller's mmio_bus. The controller
//           (master) decodes the data/status addresses and drives the strobes.
//           The UART peripheral (slave) returns the read data and status.
// Signals : tx_wen          - push uart_din into the TX FIFO this cycle
//           uart_din[7:0]   - byte to transmit
//           rx_ren          - pop the RX FIFO this cycle
//           uart_dout[7:0]  - last popped RX byte, registered
//           rx_data_present - RX FIFO non-empty
//           tx_full         - TX FIFO full
// ---------------------------------------------------------------------------
interface uart_mmio_periph_if;
   logic       tx_wen;
   logic [7:0] uart_din;
   logic       rx_ren;
   logic [7:0] uart_dout;
   logic       rx_data_present;
   logic       tx_full;

   modport master (
      output tx_wen, uart_din, rx_ren,
      input  uart_dout, rx_data_present, tx_full
   );

   modport slave (
      input  tx_wen, uart_din, rx_ren,
      output uart_dout, rx_data_present, tx_full
   );
endinterface

// File: rtl/uart_mmio_periph.sv
// ---------------------------------------------------------------------------
// uart_mmio_periph
// Purpose : Memory-mapped 8N1 UART. The TX and RX FIFOs buffer bytes between
//           the mmio bus and a bit-timed serializer/deserializer on the pins.
// Params  : CLKS_PER_BIT - clock cycles per bit period (>= 4)
//           FIFO_DEPTH   - entries per FIFO (power of two, >= 2)
// Ports   : clk - system clock
//           rst - synchronous, active-low reset
//           bus - mmio UART slice (slave side)
//           rx  - asynchronous serial input pin
//           tx  - serial output pin, idle high
// ---------------------------------------------------------------------------
module uart_mmio_periph #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic               clk,
   input  logic               rst,
   uart_mmio_periph_if.slave  bus,
   input  logic               rx,
   output logic               tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   // Bit counters run 0..CLKS_PER_BIT-1.
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] TMR_ZERO  = CW'(0);
   localparam logic [CW-1:0] TMR_ONE   = CW'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // ---------------- TX side ----------------
   logic [7:0]    tx_mem_r [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
   logic [AW:0]   tx_cnt_r;
   logic [1:0]    tx_state_r;
   logic [CW-1:0] tx_tmr_r;
   logic [2:0]    tx_bit_r;
   logic [7:0]    tx_shift_r;
   logic          tx_r;
   logic          tx_pop_s, tx_push_s;

   assign tx_pop_s  = (tx_state_r == ST_IDLE) && (tx_cnt_r != CNT_ZERO);
   // A full FIFO still accepts a write when the FSM frees the head slot this cycle.
   assign tx_push_s = bus.tx_wen && ((tx_cnt_r != CNT_FULL) || tx_pop_s);

   // TX FIFO storage write port.
   always_ff @(posedge clk) begin
      if (tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r] <= bus.uart_din;
      end
   end

   // TX FIFO pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_wr_ptr_r <= {AW{1'b0}};
         tx_rd_ptr_r <= {AW{1'b0}};
         tx_cnt_r    <= CNT_ZERO;
      end else begin
         if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
         if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_r <= tx_cnt_r + CNT_ONE;
            2'b01:   tx_cnt_r <= tx_cnt_r - CNT_ONE;
            default: tx_cnt_r <= tx_cnt_r;
         endcase
      end
   end

   // TX serializer; tx_r is loaded with the level of the state being entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state_r <= ST_IDLE;
         tx_tmr_r   <= TMR_ZERO;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         tx_r       <= 1'b1;
      end else begin
         case (tx_state_r)
            ST_IDLE: begin
               tx_tmr_r <= TMR_ZERO;
               tx_bit_r <= 3'd0;
               if (tx_pop_s) begin
                  tx_shift_r <= tx_mem_r[tx_rd_ptr_r];
                  tx_state_r <= ST_START;
                  tx_r       <= 1'b0;
               end else begin
                  tx_r       <= 1'b1;
               end
            end
            ST_START: begin
               if (tx_tmr_r == BIT_LAST) begin
                  tx_tmr_r   <= TMR_ZERO;
                  tx_state_r <= ST_DATA;
                  tx_r       <= tx_shift_r[0];
               end else begin
                  tx_tmr_r   <= tx_tmr_r + TMR_ONE;
               end
            end
            ST_DATA: begin
               if (tx_tmr_r == BIT_LAST) begin
                  tx_tmr_r <= TMR_ZERO;
                  if (tx_bit_r == 3'd7) begin
                     tx_state_r <= ST_STOP;
                     tx_r       <= 1'b1;
                  end else begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     tx_r       <= tx_shift_r[1];
                  end
               end else begin
                  tx_tmr_r <= tx_tmr_r + TMR_ONE;
               end
            end
            ST_STOP: begin
               tx_r <= 1'b1;
               if (tx_tmr_r == BIT_LAST) begin
                  tx_tmr_r   <= TMR_ZERO;
                  tx_state_r <= ST_IDLE;
               end else begin
                  tx_tmr_r   <= tx_tmr_r + TMR_ONE;
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               tx_r       <= 1'b1;
            end
         endcase
      end
   end

   // ---------------- RX side ----------------
   logic          rx_meta_r, rx_sync_r;
   logic [1:0]    rx_state_r;
   logic [CW-1:0] rx_tmr_r;
   logic [2:0]    rx_bit_r;
   logic [7:0]    rx_shift_r;
   logic [7:0]    rx_mem_r [FIFO_DEPTH];
   logic [AW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
   logic [AW:0]   rx_cnt_r;
   logic [7:0]    dout_r;
   logic          rx_frame_ok_s, rx_push_s, rx_pop_s;

   // Two-flop synchronizer for the asynchronous pin, idling high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Deserializer: re-qualify the start bit at mid-bit, then sample once per bit period.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_r <= ST_IDLE;
         rx_tmr_r   <= TMR_ZERO;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
      end else begin
         case (rx_state_r)
            ST_IDLE: begin
               rx_tmr_r <= TMR_ZERO;
               rx_bit_r <= 3'd0;
               if (!rx_sync_r) rx_state_r <= ST_START;
            end
            ST_START: begin
               if (rx_tmr_r == HALF_LAST) begin
                  rx_tmr_r   <= TMR_ZERO;
                  rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
               end else begin
                  rx_tmr_r   <= rx_tmr_r + TMR_ONE;
               end
            end
            ST_DATA: begin
               if (rx_tmr_r == BIT_LAST) begin
                  rx_tmr_r   <= TMR_ZERO;
                  rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
                  else                  rx_bit_r   <= rx_bit_r + 3'd1;
               end else begin
                  rx_tmr_r <= rx_tmr_r + TMR_ONE;
               end
            end
            ST_STOP: begin
               if (rx_tmr_r == BIT_LAST) begin
                  rx_tmr_r   <= TMR_ZERO;
                  rx_state_r <= ST_IDLE;
               end else begin
                  rx_tmr_r   <= rx_tmr_r + TMR_ONE;
               end
            end
            default: rx_state_r <= ST_IDLE;
         endcase
      end
   end

   // A low stop sample is a framing error: the byte is simply not pushed.
   assign rx_frame_ok_s = (rx_state_r == ST_STOP) && (rx_tmr_r == BIT_LAST) && rx_sync_r;
   assign rx_pop_s      = bus.rx_ren && (rx_cnt_r != CNT_ZERO);
   // Overrun drops the new byte unless a read frees a slot in the same cycle.
   assign rx_push_s     = rx_frame_ok_s && ((rx_cnt_r != CNT_FULL) || rx_pop_s);

   // RX FIFO storage write port.
   always_ff @(posedge clk) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
      end
   end

   // RX FIFO pointers, count and the registered read-data return.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_wr_ptr_r <= {AW{1'b0}};
         rx_rd_ptr_r <= {AW{1'b0}};
         rx_cnt_r    <= CNT_ZERO;
         dout_r      <= 8'h00;
      end else begin
         if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
         if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
         if (bus.rx_ren) dout_r <= rx_pop_s ? rx_mem_r[rx_rd_ptr_r] : 8'h00;
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_r <= rx_cnt_r + CNT_ONE;
            2'b01:   rx_cnt_r <= rx_cnt_r - CNT_ONE;
            default: rx_cnt_r <= rx_cnt_r;
         endcase
      end
   end

   assign tx                  = tx_r;
   assign bus.uart_dout       = dout_r;
   assign bus.rx_data_present = (rx_cnt_r != CNT_ZERO);
   assign bus.tx_full         = (tx_cnt_r == CNT_FULL);
endmodule

// File: tb/tb_uart_mmio_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_periph
// Purpose : Directed self-checking bench for uart_mmio_periph with
//           CLKS_PER_BIT=4 and FIFO_DEPTH=4. Inputs change 1 ns after the
//           rising edge; tx is logged on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_mmio_periph;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic tx;
   int   checks   = 0;
   int   failures = 0;
   logic tx_log[$];
   logic [7:0] rd;

   uart_mmio_periph_if bus();

   uart_mmio_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .rx  (rx),
      .tx  (tx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) tx_log.push_back(tx);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one 8N1 frame on rx; returns 1 ns after the edge ending the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      tick();
      for (int k = 0; k < 10; k++) begin
         rx = f[k];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic read_byte(output logic [7:0] b);
      bus.rx_ren = 1'b1;
      tick();
      bus.rx_ren = 1'b0;
      b = bus.uart_dout;
   endtask

   // tx_log[0] is the tx_wen cycle; start bit expected at index 2.
   task automatic check_tx_log(input logic [7:0] b, input string tag);
      logic [9:0] f;
      logic [3:0] obs;
      int lows;
      f = {1'b1, b, 1'b0};
      chk({tag, "_len"}, 32'(tx_log.size() >= 50), 32'd1);
      chk({tag, "_pre"}, {30'd0, tx_log[0], tx_log[1]}, 32'd3);
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < 4; c++) obs[c] = tx_log[2 + 4 * k + c];
         chk($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'({4{f[k]}}));
      end
      lows = 0;
      for (int i = 42; i < tx_log.size(); i++) if (tx_log[i] !== 1'b1) lows++;
      chk({tag, "_idle"}, 32'(lows), 32'd0);
   endtask

   // Independent frame decoder over the tx log: expects bytes 0x01..0x05 only.
   task automatic decode_tx_full();
      int pos;
      int st;
      logic [7:0] b;
      pos = 0;
      for (int fr = 0; fr < 5; fr++) begin
         st = -1;
         for (int i = pos; i < tx_log.size(); i++) if (st < 0 && tx_log[i] === 1'b0) st = i;
         chk($sformatf("txfull_found%0d", fr), 32'(st >= 0), 32'd1);
         if (st < 0) st = 0;
         for (int j = 0; j < 8; j++) b[j] = tx_log[st + 2 + 4 * (j + 1)];
         chk($sformatf("txfull_byte%0d", fr), 32'(b), 32'(fr + 1));
         chk($sformatf("txfull_stop%0d", fr), 32'(tx_log[st + 38]), 32'd1);
         pos = st + 40;
      end
      st = -1;
      for (int i = pos; i < tx_log.size(); i++) if (st < 0 && tx_log[i] === 1'b0) st = i;
      chk("txfull_no_extra", 32'(st >= 0), 32'd0);
   endtask

   initial begin
      rst          = 1'b0;
      rx           = 1'b1;
      bus.tx_wen   = 1'b0;
      bus.uart_din = 8'h00;
      bus.rx_ren   = 1'b0;
      repeat (2) tick();
      chk("rst_tx",      32'(tx), 32'd1);
      chk("rst_dout",    32'(bus.uart_dout), 32'h00);
      chk("rst_present", 32'(bus.rx_data_present), 32'd0);
      chk("rst_full",    32'(bus.tx_full), 32'd0);
      rst = 1'b1;
      tick();

      // TX single byte with exact start-bit timing.
      tx_log.delete();
      bus.uart_din = 8'h55;
      bus.tx_wen   = 1'b1;
      tick();
      bus.tx_wen   = 1'b0;
      repeat (50) tick();
      check_tx_log(8'h55, "tx55");

      // TX full: six back-to-back writes, sixth dropped.
      tx_log.delete();
      for (int i = 0; i < 6; i++) begin
         bus.uart_din = 8'(i + 1);
         bus.tx_wen   = 1'b1;
         tick();
         if (i == 3) chk("full_after4", 32'(bus.tx_full), 32'd0);
         if (i == 4) chk("full_after5", 32'(bus.tx_full), 32'd1);
         if (i == 5) chk("full_after6", 32'(bus.tx_full), 32'd1);
      end
      bus.tx_wen = 1'b0;
      repeat (230) tick();
      decode_tx_full();
      chk("full_end", 32'(bus.tx_full), 32'd0);

      // RX loopback.
      send_frame(8'hA3, 1'b1);
      tick();
      chk("lb_present", 32'(bus.rx_data_present), 32'd1);
      read_byte(rd);
      chk("lb_dout", 32'(rd), 32'hA3);
      chk("lb_present_after", 32'(bus.rx_data_present), 32'd0);
      read_byte(rd);
      chk("lb_empty_read", 32'(rd), 32'h00);

      // One-cycle glitch is a false start.
      tick();
      rx = 1'b0;
      tick();
      rx = 1'b1;
      repeat (20) tick();
      chk("glitch_present", 32'(bus.rx_data_present), 32'd0);

      // Framing error, then a good frame.
      send_frame(8'h7E, 1'b0);
      repeat (12) tick();
      chk("frame_err_present", 32'(bus.rx_data_present), 32'd0);
      send_frame(8'h3C, 1'b1);
      repeat (2) tick();
      chk("after_err_present", 32'(bus.rx_data_present), 32'd1);
      read_byte(rd);
      chk("after_err_dout", 32'(rd), 32'h3C);

      // Overrun: fifth frame dropped.
      for (int i = 0; i < 5; i++) begin
         send_frame(8'(8'h10 + i), 1'b1);
         repeat (4) tick();
      end
      chk("ovr_present", 32'(bus.rx_data_present), 32'd1);
      for (int i = 0; i < 5; i++) begin
         read_byte(rd);
         chk($sformatf("ovr_read%0d", i), 32'(rd), (i < 4) ? 32'(8'h10 + i) : 32'h00);
      end

      // Overrun rescued by a read in the push cycle of the fifth frame.
      for (int i = 0; i < 4; i++) begin
         send_frame(8'(8'h10 + i), 1'b1);
         repeat (4) tick();
      end
      send_frame(8'h14, 1'b1);
      bus.rx_ren = 1'b1;
      tick();
      bus.rx_ren = 1'b0;
      chk("ovr2_read0", 32'(bus.uart_dout), 32'h10);
      for (int i = 1; i < 6; i++) begin
         read_byte(rd);
         chk($sformatf("ovr2_read%0d", i), 32'(rd), (i < 5) ? 32'(8'h10 + i) : 32'h00);
      end

      // Reset mid-frame with TX FIFO full and an unread RX byte.
      send_frame(8'h5A, 1'b1);
      repeat (4) tick();
      send_frame(8'h5A, 1'b1);
      repeat (4) tick();
      read_byte(rd);
      chk("pre_rst_dout", 32'(rd), 32'h5A);
      chk("pre_rst_present", 32'(bus.rx_data_present), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus.uart_din = 8'h00;
         bus.tx_wen   = 1'b1;
         tick();
      end
      bus.tx_wen = 1'b0;
      tick();
      tick();
      chk("pre_rst_tx", 32'(tx), 32'd0);
      chk("pre_rst_full", 32'(bus.tx_full), 32'd1);
      rst = 1'b0;
      tick();
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_full", 32'(bus.tx_full), 32'd0);
      chk("mid_rst_dout", 32'(bus.uart_dout), 32'h00);
      chk("mid_rst_present", 32'(bus.rx_data_present), 32'd0);
      rst = 1'b1;
      tick();

      // Clean frame after reset release.
      tx_log.delete();
      bus.uart_din = 8'h81;
      bus.tx_wen   = 1'b1;
      tick();
      bus.tx_wen   = 1'b0;
      repeat (50) tick();
      check_tx_log(8'h81, "tx81");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_mmio_periph.md
# uart_mmio_periph

Memory-mapped UART peripheral on the consumer side of the memory controller's `mmio_bus` UART signals. Decodes nothing itself: the controller asserts `tx_wen` and `rx_ren` for address `0xAAAAA400`, and reads status at `0xAAAAA404` from `tx_full` and `rx_data_present`. The block buffers transmit and receive bytes in FIFOs and runs an 8N1 serializer/deserializer on the board pins.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit period (100 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 16: entries per FIFO; power of two, ≥ 2.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: reset, synchronous, active-low.
- `tx_wen` in 1: push `uart_din` into TX FIFO this cycle.
- `uart_din` in 8: byte to transmit.
- `rx_ren` in 1: pop RX FIFO this cycle.
- `uart_dout` out 8: last popped RX byte, registered.
- `rx_data_present` out 1: RX FIFO non-empty.
- `tx_full` out 1: TX FIFO full.
- `rx` in 1: serial input pin, asynchronous.
- `tx` out 1: serial output pin, idle high.

## Operation
- **TX FIFO:**
  - A push occurs on `tx_wen`. It is accepted if the FIFO is not full, or if the TX FSM pops in the same cycle. Otherwise the byte is silently dropped.
  - One push per cycle while `tx_wen` is high.
- **TX FSM, states IDLE/START/DATA/STOP:**
  - IDLE: with the FIFO non-empty, pop the head into the shift register and go to START. Holds `tx=1`.
  - START: `tx=0` for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each bit held for `CLKS_PER_BIT` cycles.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles, then IDLE.
  - Back-to-back frames add one IDLE cycle between them.
- **RX front end:** `rx` passes through a 2-flop synchronizer, reset value 1. All RX logic uses the synchronized value.
- **RX FSM, states IDLE/START/DATA/STOP:**
  - IDLE: a low sample moves to START.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then resample. If low, go to DATA. If high, it was a false start: return to IDLE with nothing pushed.
  - DATA: sample every `CLKS_PER_BIT` cycles from the mid-start point. 8 samples, LSB first.
  - STOP: sample once after `CLKS_PER_BIT` cycles, then return to IDLE.
    - Stop bit high: push the byte.
    - Stop bit low: framing error; discard the byte. No flag is raised.
- **RX FIFO:**
  - A push is accepted if the FIFO is not full, or if `rx_ren` pops in the same cycle. Otherwise it is an overrun and the new byte is dropped.
  - On `rx_ren` with the FIFO non-empty: `uart_dout <= head`, and the head is popped.
  - On `rx_ren` with the FIFO empty: `uart_dout <= 8'h00`, and FIFO state is unchanged.
  - With `rx_ren` low, `uart_dout` holds its value.
- **FIFO pointers:** read and write pointers are `log2(FIFO_DEPTH)` bits, with a separate count of `log2(FIFO_DEPTH)+1` bits. Pointers wrap modulo depth. A simultaneous push and pop leaves the count unchanged.
- **Status outputs:** `rx_data_present` and `tx_full` are decoded from registered counts; they are not combinational on the inputs.

## Timing
- **Reset:** `rst` low at a `clk` edge forces, on that edge:
  - `tx=1`, `uart_dout=8'h00`, `rx_data_present=0`, `tx_full=0`;
  - both FIFOs empty, both FSMs in IDLE, counters 0, synchronizer = 1.
- **Reset mid-frame:** the frame is truncated and `tx` is high on the next cycle. A partial RX byte is discarded.
- **Read latency:** `rx_ren` high in cycle N gives valid `uart_dout` in cycle N+1. This matches the controller's one-cycle-delayed return mux.
- **Status update:** `rx_data_present` and `tx_full` reflect a push or pop in cycle N from cycle N+1.
- **TX latency:**
  - First write into an empty FIFO with the FSM idle, `tx_wen` in cycle N: pop at N+1, start bit on `tx` from N+2.
  - A frame lasts 10·`CLKS_PER_BIT` cycles.
- **RX push timing:** the push is visible (`rx_data_present=1`) 1 cycle after the stop-bit sample. Worst case that is 2 sync cycles + 9.5·`CLKS_PER_BIT` + 1 after the falling start edge on the pin.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- **TX single byte:** write 0x55 -> `tx` shows 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 4 cycles, start bit beginning 2 cycles after `tx_wen`; then `tx=1`.
- **TX full:**
  - Back-to-back writes 0x01..0x06 with TX idle: 0x01 moves to the shift register, so `tx_full=1` after the 5th write and 0x06 is dropped.
  - Exactly 0x01..0x05 are transmitted.
- **RX loopback:**
  - Drive `rx` with frame 0xA3 -> `rx_data_present=1`.
  - Then `rx_ren` for 1 cycle -> `uart_dout=0xA3` next cycle and `rx_data_present=0`.
  - Then `rx_ren` again -> `uart_dout=0x00`.
- **RX errors:**
  - A 1-cycle low glitch on `rx` -> no push.
  - Frame 0x7E with the stop bit low -> no push. The next valid frame 0x3C is received correctly.
- **RX overrun:**
  - Send 5 frames 0x10..0x14 without reads. Then 4 reads return 0x10..0x13, and the 5th read returns 0x00.
  - Repeat, but hold `rx_ren` for 1 cycle in the same cycle as the 5th frame's push -> 0x14 is retained.
- **Reset mid-frame:**
  - Assert `rst` low during a TX data bit -> `tx=1` next cycle, `tx_full=0`, `uart_dout=0x00`.
  - After release, write 0x81 -> a clean frame is transmitted.
